// File: rtl/alu_rr_scheduler_if.sv
// Command, core and response signals shared by the scheduler, its two
// requesters and the ALU/NPU core.
interface alu_rr_scheduler_if #(
  parameter int unsigned CNT_W = 8
);
  logic             stall;

  logic             req0_valid;
  logic             req0_ready;
  logic             req0_mode;
  logic [3:0]       req0_op;
  logic [3:0]       req0_a;
  logic [3:0]       req0_b;

  logic             req1_valid;
  logic             req1_ready;
  logic             req1_mode;
  logic [3:0]       req1_op;
  logic [3:0]       req1_a;
  logic [3:0]       req1_b;

  logic             alu_valid;
  logic             alu_mode;
  logic [3:0]       alu_op;
  logic [3:0]       alu_a;
  logic [3:0]       alu_b;
  logic [3:0]       alu_result;
  logic [3:0]       alu_flags;

  logic             resp0_valid;
  logic [3:0]       resp0_result;
  logic [3:0]       resp0_flags;
  logic             resp1_valid;
  logic [3:0]       resp1_result;
  logic [3:0]       resp1_flags;

  logic [CNT_W-1:0] done_cnt0;
  logic [CNT_W-1:0] done_cnt1;
  logic             idle;

  // Scheduler side
  modport slave (
    input  stall,
    input  req0_valid, req0_mode, req0_op, req0_a, req0_b,
    output req0_ready,
    input  req1_valid, req1_mode, req1_op, req1_a, req1_b,
    output req1_ready,
    output alu_valid, alu_mode, alu_op, alu_a, alu_b,
    input  alu_result, alu_flags,
    output resp0_valid, resp0_result, resp0_flags,
    output resp1_valid, resp1_result, resp1_flags,
    output done_cnt0, done_cnt1, idle
  );

  // Host requesters plus core
  modport master (
    output stall,
    output req0_valid, req0_mode, req0_op, req0_a, req0_b,
    input  req0_ready,
    output req1_valid, req1_mode, req1_op, req1_a, req1_b,
    input  req1_ready,
    input  alu_valid, alu_mode, alu_op, alu_a, alu_b,
    output alu_result, alu_flags,
    input  resp0_valid, resp0_result, resp0_flags,
    input  resp1_valid, resp1_result, resp1_flags,
    input  done_cnt0, done_cnt1, idle
  );
endinterface

// File: rtl/alu_rr_scheduler.sv
// Round-robin scheduler sharing one pipelined ALU/NPU core between two
// requesters. Issues at most one op per cycle, tags it with its requester and
// routes the core's result/flags back ALU_LAT+2 cycles after the handshake.
module alu_rr_scheduler #(
  parameter int unsigned ALU_LAT = 2,
  parameter int unsigned CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  alu_rr_scheduler_if.slave  bus
);

  typedef enum logic {
    PRI_REQ0 = 1'b0,
    PRI_REQ1 = 1'b1
  } pri_e;

  pri_e             pri_q, pri_d;
  logic             gnt0, gnt1, xfer;

  logic             alu_valid_q;
  logic             alu_id_q;
  logic             alu_mode_q;
  logic [3:0]       alu_op_q, alu_a_q, alu_b_q;

  logic [ALU_LAT-1:0] tag_v, tag_id;
  logic             tail_v, tail_id;

  logic             resp0_valid_q, resp1_valid_q;
  logic [3:0]       resp0_result_q, resp0_flags_q;
  logic [3:0]       resp1_result_q, resp1_flags_q;
  logic [CNT_W-1:0] cnt0_q, cnt1_q;

  // Grant from valids, stall and the priority pointer; pointer flips to the
  // other requester after any transfer.
  always_comb begin
    gnt0  = 1'b0;
    gnt1  = 1'b0;
    pri_d = pri_q;
    if (!bus.stall) begin
      if (bus.req0_valid && bus.req1_valid) begin
        gnt0 = (pri_q == PRI_REQ0);
        gnt1 = (pri_q == PRI_REQ1);
      end else begin
        gnt0 = bus.req0_valid;
        gnt1 = bus.req1_valid;
      end
    end
    if (gnt0) begin
      pri_d = PRI_REQ1;
    end else if (gnt1) begin
      pri_d = PRI_REQ0;
    end
  end

  assign xfer = gnt0 | gnt1;

  // Priority pointer register
  always_ff @(posedge clk) begin
    if (rst) begin
      pri_q <= PRI_REQ0;
    end else begin
      pri_q <= pri_d;
    end
  end

  // Issue stage: capture the granted command; fields hold when nothing issues
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_valid_q <= 1'b0;
      alu_id_q    <= 1'b0;
      alu_mode_q  <= 1'b0;
      alu_op_q    <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
    end else begin
      alu_valid_q <= xfer;
      if (xfer) begin
        alu_id_q   <= gnt1;
        alu_mode_q <= gnt1 ? bus.req1_mode : bus.req0_mode;
        alu_op_q   <= gnt1 ? bus.req1_op   : bus.req0_op;
        alu_a_q    <= gnt1 ? bus.req1_a    : bus.req0_a;
        alu_b_q    <= gnt1 ? bus.req1_b    : bus.req0_b;
      end
    end
  end

  // Tag shift register tracking each issued op through the core's latency;
  // stage ALU_LAT-1 lines up with the cycle the core's result is valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_v  <= '0;
      tag_id <= '0;
    end else begin
      tag_v[0]  <= alu_valid_q;
      tag_id[0] <= alu_id_q;
      for (int unsigned i = 1; i < ALU_LAT; i++) begin
        tag_v[i]  <= tag_v[i-1];
        tag_id[i] <= tag_id[i-1];
      end
    end
  end

  assign tail_v  = tag_v[ALU_LAT-1];
  assign tail_id = tag_id[ALU_LAT-1];

  // Response capture and completion counters; the counter steps on the same
  // edge that raises resp_valid, so it already shows the new count in that
  // cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp0_valid_q  <= 1'b0;
      resp1_valid_q  <= 1'b0;
      resp0_result_q <= '0;
      resp0_flags_q  <= '0;
      resp1_result_q <= '0;
      resp1_flags_q  <= '0;
      cnt0_q         <= '0;
      cnt1_q         <= '0;
    end else begin
      resp0_valid_q <= tail_v & ~tail_id;
      resp1_valid_q <= tail_v &  tail_id;
      if (tail_v && !tail_id) begin
        resp0_result_q <= bus.alu_result;
        resp0_flags_q  <= bus.alu_flags;
        cnt0_q         <= cnt0_q + 1'b1;
      end
      if (tail_v && tail_id) begin
        resp1_result_q <= bus.alu_result;
        resp1_flags_q  <= bus.alu_flags;
        cnt1_q         <= cnt1_q + 1'b1;
      end
    end
  end

  assign bus.req0_ready   = gnt0;
  assign bus.req1_ready   = gnt1;
  assign bus.alu_valid    = alu_valid_q;
  assign bus.alu_mode     = alu_mode_q;
  assign bus.alu_op       = alu_op_q;
  assign bus.alu_a        = alu_a_q;
  assign bus.alu_b        = alu_b_q;
  assign bus.resp0_valid  = resp0_valid_q;
  assign bus.resp0_result = resp0_result_q;
  assign bus.resp0_flags  = resp0_flags_q;
  assign bus.resp1_valid  = resp1_valid_q;
  assign bus.resp1_result = resp1_result_q;
  assign bus.resp1_flags  = resp1_flags_q;
  assign bus.done_cnt0    = cnt0_q;
  assign bus.done_cnt1    = cnt1_q;
  assign bus.idle         = ~(|tag_v) & ~alu_valid_q & ~resp0_valid_q & ~resp1_valid_q;

endmodule
